// File: rtl/ex_mem_if.sv
// ex_mem_if: EX->MEM pipeline handshake, flush and payload bundle.
// The master drives the EX side and consumes on the MEM side; the stage is the slave.
interface ex_mem_if #(parameter int DATA_WIDTH = 32);
  logic flush, valid_e, ready_e, valid_m, ready_m;
  logic RegWriteE, MemWriteE, RegWriteM, MemWriteM;
  logic [1:0] ResultSrcE, ResultSrcM;
  logic [2:0] funct3E, funct3M;
  logic [4:0] RdE, RdM;
  logic [DATA_WIDTH-1:0] ALUResultE, WriteDataE, PCPlus4E;
  logic [DATA_WIDTH-1:0] ALUResultM, WriteDataM, PCPlus4M;
  modport master (
    output flush, valid_e, ready_m, RegWriteE, MemWriteE, ResultSrcE, funct3E, RdE,
           ALUResultE, WriteDataE, PCPlus4E,
    input  ready_e, valid_m, RegWriteM, MemWriteM, ResultSrcM, funct3M, RdM,
           ALUResultM, WriteDataM, PCPlus4M
  );
  modport slave (
    input  flush, valid_e, ready_m, RegWriteE, MemWriteE, ResultSrcE, funct3E, RdE,
           ALUResultE, WriteDataE, PCPlus4E,
    output ready_e, valid_m, RegWriteM, MemWriteM, ResultSrcM, funct3M, RdM,
           ALUResultM, WriteDataM, PCPlus4M
  );
endinterface

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX/MEM pipeline register with valid/ready handshake and flush.
// Define EX_MEM_SKID_EN for a main+skid two-entry buffer with a registered ready_e.
module ex_mem_stage #(parameter int DATA_WIDTH = 32) (
  input logic     clk,
  input logic     rst,
  ex_mem_if.slave bus
);
  typedef struct packed {
    logic                  reg_write;
    logic                  mem_write;
    logic [1:0]            result_src;
    logic [2:0]            funct3;
    logic [4:0]            rd;
    logic [DATA_WIDTH-1:0] alu_result;
    logic [DATA_WIDTH-1:0] write_data;
    logic [DATA_WIDTH-1:0] pc_plus4;
  } entry_t;
  entry_t in_w, main_q;
  logic   valid, accept;
  assign in_w = {bus.RegWriteE, bus.MemWriteE, bus.ResultSrcE, bus.funct3E, bus.RdE,
                 bus.ALUResultE, bus.WriteDataE, bus.PCPlus4E};
  assign bus.valid_m    = valid;
  assign bus.RegWriteM  = valid & main_q.reg_write;
  assign bus.MemWriteM  = valid & main_q.mem_write;
  assign bus.ResultSrcM = main_q.result_src;
  assign bus.funct3M    = main_q.funct3;
  assign bus.RdM        = main_q.rd;
  assign bus.ALUResultM = main_q.alu_result;
  assign bus.WriteDataM = main_q.write_data;
  assign bus.PCPlus4M   = main_q.pc_plus4;
`ifdef EX_MEM_SKID_EN
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  state_t state_q;
  entry_t skid_q;
  logic   ready_q;
  assign bus.ready_e = ready_q;
  assign accept      = bus.valid_e && ready_q;
  assign valid       = state_q != EMPTY;
  // main_q always holds the oldest entry; skid_q only the one caught while stalled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EMPTY;
      ready_q <= 1'b1;
      main_q  <= '0;
      skid_q  <= '0;
    end else if (bus.flush) begin
      state_q <= EMPTY;
      ready_q <= 1'b1;
    end else begin
      case (state_q)
        EMPTY: if (accept) begin
          main_q  <= in_w;
          state_q <= ONE;
        end
        ONE: if (accept && !bus.ready_m) begin
          skid_q  <= in_w;
          state_q <= TWO;
          ready_q <= 1'b0;
        end else if (accept) main_q <= in_w;
        else if (bus.ready_m) state_q <= EMPTY;
        default: if (bus.ready_m) begin
          main_q  <= skid_q;
          state_q <= ONE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end
`else
  logic valid_q;
  assign valid       = valid_q;
  assign bus.ready_e = !valid_q || bus.ready_m;
  assign accept      = bus.valid_e && bus.ready_e;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      main_q  <= '0;
    end else begin
      valid_q <= !bus.flush && (accept || (valid_q && !bus.ready_m));
      if (accept && !bus.flush) main_q <= in_w;
    end
  end
`endif
endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: scoreboard bench for ex_mem_stage (works with or without EX_MEM_SKID_EN).
module tb_ex_mem_stage;
  localparam int W = 32;
  typedef struct packed {
    logic rw, mw; logic [1:0] rs; logic [2:0] f3; logic [4:0] rd;
    logic [W-1:0] alu, wd, pc;
  } ent_t;
  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;
  ex_mem_if #(.DATA_WIDTH(W)) bus();
  ex_mem_stage #(.DATA_WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
  ent_t exp_q[$];
  int tests = 0, fails = 0;

  function automatic ent_t out_now();
    return {bus.RegWriteM, bus.MemWriteM, bus.ResultSrcM, bus.funct3M, bus.RdM,
            bus.ALUResultM, bus.WriteDataM, bus.PCPlus4M};
  endfunction

  function automatic ent_t mk(logic rw, logic mw, logic [1:0] rs, logic [2:0] f3,
                              logic [4:0] rd, logic [W-1:0] alu);
    return {rw, mw, rs, f3, rd, alu, alu ^ 32'h0000_FFFF, alu + 32'd4};
  endfunction

  task automatic check(string name, logic [127:0] act, logic [127:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Called at posedge+1: drive inputs, push the expected entry if it is accepted, return at next posedge+1.
  task automatic cycle(input logic v, input logic rm, input logic fl, input ent_t e);
    bus.valid_e = v;
    bus.ready_m = rm;
    bus.flush   = fl;
    {bus.RegWriteE, bus.MemWriteE, bus.ResultSrcE, bus.funct3E, bus.RdE,
     bus.ALUResultE, bus.WriteDataE, bus.PCPlus4E} = e;
    @(negedge clk);
    if (rst && v && bus.ready_e && !fl) exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops on every downstream transfer, checks stall hold and bubble gating.
  ent_t prev_out, got;
  logic stall_prev = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      stall_prev = 1'b0;
    end else begin
      if (!bus.valid_m) check("bubble_gate", {bus.RegWriteM, bus.MemWriteM}, 2'b00);
      if (stall_prev) check("stall_hold", out_now(), prev_out);
      if (bus.flush) exp_q.delete();
      else if (bus.valid_m && bus.ready_m) begin
        if (exp_q.size() == 0) check("unexpected_out", out_now(), '1);
        else begin
          got = exp_q.pop_front();
          check("entry_order", out_now(), got);
        end
      end
      stall_prev = bus.valid_m && !bus.ready_m && !bus.flush;
      prev_out = out_now();
    end
  end

  initial begin
    ent_t e5, e6;
    e5 = mk(1'b1, 1'b0, 2'd1, 3'd2, 5'd5, 32'h55);
    e6 = mk(1'b0, 1'b1, 2'd0, 3'd0, 5'd6, 32'h66);
    // reset with live, write-enabled upstream traffic
    bus.valid_e = 1'b1; bus.ready_m = 1'b1; bus.flush = 1'b0;
    {bus.RegWriteE, bus.MemWriteE, bus.ResultSrcE, bus.funct3E, bus.RdE,
     bus.ALUResultE, bus.WriteDataE, bus.PCPlus4E} = mk(1'b1, 1'b1, 2'd3, 3'd7, 5'd31, 32'hDEAD);
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid_m", bus.valid_m, 1'b0);
    check("reset_regwrite", bus.RegWriteM, 1'b0);
    check("reset_outputs", out_now(), '0);
    bus.valid_e = 1'b0;
    rst = 1'b1;
    check("ready_after_reset", bus.ready_e, 1'b1);
    // back-to-back stream with ready_m high
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b1, 1'b0, mk(1'b1, 1'b0, 2'd0, 3'd2, 5'(i + 1), 32'h10 * (i + 1)));
      check("stream_valid", bus.valid_m, 1'b1);
      check("stream_alu", bus.ALUResultM, 32'h10 * (i + 1));
    end
    cycle(1'b0, 1'b1, 1'b0, '0);
    check("stream_drained", bus.valid_m, 1'b0);
    // backpressure: entry Rd=5 then 3 stalled cycles offering Rd=6
    cycle(1'b1, 1'b0, 1'b0, e5);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 1'b0, 1'b0, e6);
      check("stall_rd", bus.RdM, 5'd5);
      check("stall_valid", bus.valid_m, 1'b1);
      check("stall_ready_e", bus.ready_e, 1'b0);
    end
    cycle(1'b1, 1'b1, 1'b0, e6);
    check("release_rd", bus.RdM, 5'd6);
    cycle(1'b0, 1'b1, 1'b0, '0);
    check("release_drained", bus.valid_m, 1'b0);
    // flush overrides a simultaneous accept
    cycle(1'b1, 1'b1, 1'b1, mk(1'b0, 1'b1, 2'd0, 3'd2, 5'd9, 32'h99));
    check("flush_accept_valid", bus.valid_m, 1'b0);
    check("flush_accept_memwrite", bus.MemWriteM, 1'b0);
    // flush overrides accept and consume while holding an entry
    cycle(1'b1, 1'b0, 1'b0, e5);
    cycle(1'b1, 1'b1, 1'b1, e6);
    check("flush_held_valid", bus.valid_m, 1'b0);
    // bubbles with RegWriteE held high
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 1'b1, 1'b0, mk(1'b1, 1'b1, 2'd1, 3'd1, 5'd7, 32'h77));
      check("bubble_regwrite", bus.RegWriteM, 1'b0);
    end
    // async reset in the middle of a stall with a second entry offered
    cycle(1'b1, 1'b0, 1'b0, e5);
    cycle(1'b1, 1'b0, 1'b0, e6);
    #2 rst = 1'b0;
    #1;
    check("async_valid_m", bus.valid_m, 1'b0);
    check("async_outputs", out_now(), '0);
    bus.valid_e = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    check("async_ready_e", bus.ready_e, 1'b1);
    check("async_empty", bus.valid_m, 1'b0);
    // recovery after reset
    cycle(1'b1, 1'b1, 1'b0, mk(1'b1, 1'b0, 2'd2, 3'd4, 5'd12, 32'hABCD));
    check("recover_alu", bus.ALUResultM, 32'hABCD);
    cycle(1'b0, 1'b1, 1'b0, '0);
    cycle(1'b0, 1'b1, 1'b0, '0);
    check("queue_drained", 128'(exp_q.size()), 128'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
